// File: rtl/udp_rx_pkg.sv
// Shared types, protocol constants and helpers for the multi-source UDP receiver.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StEth,
        StIp,
        StUdp,
        StData,
        StEnd
    } state_t;

    // Byte indices within each header section (counter starts at 0 per section)
    localparam logic [15:0] PREAMBLE_REPEAT = 16'd6;
    localparam logic [15:0] ETH_HDR_LAST    = 16'd13;
    localparam logic [15:0] IP_PROTO_IDX    = 16'd9;
    localparam logic [15:0] IP_DST_LAST     = 16'd19;
    localparam logic [15:0] UDP_PORT_LAST   = 16'd3;
    localparam logic [15:0] UDP_LEN_LAST    = 16'd5;
    localparam logic [15:0] UDP_HDR_LAST    = 16'd7;
    localparam logic [15:0] UDP_HDR_LEN     = 16'd8;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hd5;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam logic [47:0] MAC_BROADCAST = 48'hff_ff_ff_ff_ff_ff;

    // One-hot of the lowest table entry equal to mac; table holds up to 8 entries
    function automatic logic [7:0] onehot_match(input logic [47:0] mac,
                                                input logic [383:0] tbl,
                                                input int unsigned n);
        logic [7:0] hit;
        logic found;
        hit = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && i < n && tbl[48*i +: 48] == mac) begin
                hit[i] = 1'b1;
                found = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/udp_rx_multi_crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected, init all-ones, no final inversion).
// crc is presented MSB-first so a good frame plus FCS leaves 32'hC704DD7B.
module crc32_d8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    // Eight LSB-first shift steps of the reflected polynomial
    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i]) begin
                crc_next = (crc_next >> 1) ^ 32'hEDB88320;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

    // CRC register: seeded on init, advanced on each enabled byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= 32'hFFFF_FFFF;
        end else if (init) begin
            crc_reg <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    // Bit-reverse into the MSB-first residue form
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            crc[i] = crc_reg[31-i];
        end
    end

endmodule

// File: rtl/udp_rx_multi.sv
// GMII UDP receiver: filters on board MAC/IP/port, tags the source from a MAC
// table and packs payload into DATA_W-bit big-endian words with a byte count.
// Optional: define UDP_RX_CRC_EN to check the FCS and defer rec_pkt_done until
// after dv falls.
module udp_rx_multi
    import udp_rx_pkg::*;
#(
    parameter logic [47:0]           BOARD_MAC     = 48'h00_11_22_33_44_55,
    parameter logic [31:0]           BOARD_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0]           BOARD_PORT    = 16'd1234,
    parameter int unsigned           NUM_SRC       = 2,
    parameter logic [48*NUM_SRC-1:0] SRC_MAC_TABLE = {NUM_SRC{48'hff_ff_ff_ff_ff_ff}},
    parameter int unsigned           DATA_W        = 8,
    localparam int unsigned          KEEP_W        = $clog2(DATA_W / 8) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gmii_rx_dv,
    input  logic [7:0]         gmii_rxd,
    output logic               rec_en,
    output logic [DATA_W-1:0]  rec_data,
    output logic [KEEP_W-1:0]  rec_keep,
    output logic               rec_pkt_done,
    output logic               rec_pkt_err,
    output logic [15:0]        rec_byte_num,
    output logic [NUM_SRC-1:0] src_id,
    output logic [15:0]        drop_cnt
);

    localparam int unsigned BYTES = DATA_W / 8;

    state_t              state;
    logic [15:0]         cnt;
    logic [103:0]        sh;        // last 13 received bytes, newest in the LSBs
    logic [3:0]          ihl;
    logic [15:0]         udp_len;
    logic [DATA_W-1:0]   pack;
    logic [KEEP_W-1:0]   pcnt;

    logic                error_en;
    logic                skip_en;
    logic [111:0]        eth_full;
    logic                dst_ok;
    logic [NUM_SRC-1:0]  src_hit;
    logic [15:0]         ip_last;
    logic [15:0]         pay_len;
    logic                pay_last;
    logic [DATA_W-1:0]   byte_word;
    logic [DATA_W-1:0]   pack_next;
    logic                word_full;

    assign eth_full  = {sh, gmii_rxd};
    assign dst_ok    = (eth_full[111:64] == BOARD_MAC) || (eth_full[111:64] == MAC_BROADCAST);
    assign src_hit   = NUM_SRC'(onehot_match(eth_full[63:16], 384'(SRC_MAC_TABLE), NUM_SRC));
    assign ip_last   = {10'd0, ihl, 2'b00} - 16'd1;
    assign pay_len   = udp_len - UDP_HDR_LEN;
    assign pay_last  = (cnt == pay_len - 16'd1);
    assign byte_word = DATA_W'(gmii_rxd) << (DATA_W - 8);
    assign pack_next = pack | (byte_word >> (8 * pcnt));
    assign word_full = (pcnt == KEEP_W'(BYTES - 1));

`ifdef UDP_RX_CRC_EN
    logic        pend;
    logic [31:0] crc;

    crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state == StIdle || state == StPreamble),
        .en   (gmii_rx_dv && state != StIdle && state != StPreamble),
        .data (gmii_rxd),
        .crc  (crc)
    );
`endif

    // Header checks: error_en drops the frame, skip_en advances to the next section
    always_comb begin
        error_en = 1'b0;
        skip_en  = 1'b0;
        unique case (state)
            StPreamble: begin
                if (!gmii_rx_dv) begin
                    error_en = 1'b1;
                end else if (cnt < PREAMBLE_REPEAT) begin
                    error_en = (gmii_rxd != PREAMBLE_BYTE);
                end else begin
                    error_en = (gmii_rxd != SFD_BYTE);
                    skip_en  = !error_en;
                end
            end
            StEth: begin
                if (!gmii_rx_dv) begin
                    error_en = 1'b1;
                end else if (cnt == ETH_HDR_LAST) begin
                    error_en = !dst_ok || (eth_full[15:0] != ETH_TYPE_IPV4) || (src_hit == '0);
                    skip_en  = !error_en;
                end
            end
            StIp: begin
                if (!gmii_rx_dv) begin
                    error_en = 1'b1;
                end else begin
                    if (cnt == 16'd0 && gmii_rxd[3:0] < 4'd5) error_en = 1'b1;
                    if (cnt == IP_PROTO_IDX && gmii_rxd != IP_PROTO_UDP) error_en = 1'b1;
                    if (cnt == IP_DST_LAST && {sh[23:0], gmii_rxd} != BOARD_IP) error_en = 1'b1;
                    skip_en = !error_en && cnt >= IP_DST_LAST && cnt == ip_last;
                end
            end
            StUdp: begin
                if (!gmii_rx_dv) begin
                    error_en = 1'b1;
                end else begin
                    if (cnt == UDP_PORT_LAST && {sh[7:0], gmii_rxd} != BOARD_PORT) error_en = 1'b1;
                    if (cnt == UDP_LEN_LAST && {sh[7:0], gmii_rxd} < UDP_HDR_LEN) error_en = 1'b1;
                    skip_en = !error_en && cnt == UDP_HDR_LAST;
                end
            end
            default: ;
        endcase
    end

    // Frame FSM with registered outputs and the payload packer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            sh           <= '0;
            ihl          <= '0;
            udp_len      <= '0;
            pack         <= '0;
            pcnt         <= '0;
            rec_en       <= 1'b0;
            rec_data     <= '0;
            rec_keep     <= '0;
            rec_pkt_done <= 1'b0;
            rec_pkt_err  <= 1'b0;
            rec_byte_num <= '0;
            src_id       <= '0;
`ifdef UDP_RX_CRC_EN
            pend         <= 1'b0;
`endif
        end else begin
            rec_en       <= 1'b0;
            rec_pkt_done <= 1'b0;
            rec_pkt_err  <= 1'b0;
            if (gmii_rx_dv) sh <= {sh[95:0], gmii_rxd};
            if (error_en) begin
                state <= StEnd;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (gmii_rx_dv) begin
                            cnt   <= '0;
                            state <= (gmii_rxd == PREAMBLE_BYTE) ? StPreamble : StEnd;
                        end
                    end
                    StPreamble, StEth: begin
                        if (skip_en) begin
                            cnt   <= '0;
                            state <= (state == StPreamble) ? StEth : StIp;
                            if (state == StEth) src_id <= src_hit;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    StIp: begin
                        if (cnt == 16'd0) ihl <= gmii_rxd[3:0];
                        if (skip_en) begin
                            cnt   <= '0;
                            state <= StUdp;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    StUdp: begin
                        if (cnt == UDP_LEN_LAST) udp_len <= {sh[7:0], gmii_rxd};
                        if (skip_en) begin
                            cnt <= '0;
                            if (udp_len == UDP_HDR_LEN) begin
                                // Empty payload: report completion straight away
                                rec_byte_num <= '0;
`ifdef UDP_RX_CRC_EN
                                pend         <= 1'b1;
`else
                                rec_pkt_done <= 1'b1;
`endif
                                state        <= StEnd;
                            end else begin
                                state <= StData;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    StData: begin
                        if (gmii_rx_dv) begin
                            cnt <= cnt + 16'd1;
                            if (word_full || pay_last) begin
                                rec_en   <= 1'b1;
                                rec_data <= pack_next;
                                rec_keep <= pcnt + KEEP_W'(1);
                                pack     <= '0;
                                pcnt     <= '0;
                            end else begin
                                pack <= pack_next;
                                pcnt <= pcnt + KEEP_W'(1);
                            end
                            if (pay_last) begin
                                rec_byte_num <= pay_len;
`ifdef UDP_RX_CRC_EN
                                pend         <= 1'b1;
`else
                                rec_pkt_done <= 1'b1;
`endif
                                state        <= StEnd;
                            end
                        end else begin
                            // Truncated payload: flush what we have and flag it
                            if (pcnt != '0) begin
                                rec_en   <= 1'b1;
                                rec_data <= pack;
                                rec_keep <= pcnt;
                            end
                            pack         <= '0;
                            pcnt         <= '0;
                            rec_byte_num <= cnt;
                            rec_pkt_done <= 1'b1;
                            rec_pkt_err  <= 1'b1;
                            state        <= StEnd;
                        end
                    end
                    StEnd: begin
                        if (!gmii_rx_dv) begin
                            state  <= StIdle;
                            src_id <= '0;
`ifdef UDP_RX_CRC_EN
                            if (pend) begin
                                rec_pkt_done <= 1'b1;
                                rec_pkt_err  <= (crc != CRC_RESIDUE);
                                pend         <= 1'b0;
                            end
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // Saturating count of filtered frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (error_en && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_rx_multi.sv
// Scoreboard bench for udp_rx_multi (DATA_W=32, two sources).
module tb_udp_rx_multi;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [15:0] PORT      = 16'd1234;
    localparam logic [47:0] MAC_A     = 48'h02_00_00_00_00_0A;
    localparam logic [47:0] MAC_B     = 48'h02_00_00_00_00_0B;
    localparam logic [47:0] MAC_UNK   = 48'h02_00_00_00_00_0C;
    localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        rec_en;
    logic [31:0] rec_data;
    logic [2:0]  rec_keep;
    logic        rec_pkt_done;
    logic        rec_pkt_err;
    logic [15:0] rec_byte_num;
    logic [1:0]  src_id;
    logic [15:0] drop_cnt;

    always #4 clk = ~clk;

    udp_rx_multi #(
        .BOARD_MAC     (BOARD_MAC),
        .BOARD_IP      (BOARD_IP),
        .BOARD_PORT    (PORT),
        .NUM_SRC       (2),
        .SRC_MAC_TABLE ({MAC_B, MAC_A}),
        .DATA_W        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_keep     (rec_keep),
        .rec_pkt_done (rec_pkt_done),
        .rec_pkt_err  (rec_pkt_err),
        .rec_byte_num (rec_byte_num),
        .src_id       (src_id),
        .drop_cnt     (drop_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  keep;
    } word_t;

    typedef struct packed {
        logic        err;
        logic [15:0] num;
        logic [1:0]  src;
    } done_t;

    word_t      exp_w[$];
    done_t      exp_d[$];
    logic [7:0] frm[$];
    logic [7:0] pay[$];
    logic [1:0] seen_src = 2'b00;
    int         vectors = 0;
    int         miscompares = 0;

`ifdef UDP_RX_CRC_EN
    localparam logic BAD_FCS_ERR = 1'b1;
`else
    localparam logic BAD_FCS_ERR = 1'b0;
`endif

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Scoreboard: pop and compare whenever the DUT emits a word or a done pulse
    task automatic sample();
        word_t w;
        done_t d;
        if (rst) seen_src = 2'b00;
        if (src_id != 2'b00) seen_src = src_id;
        if (rec_en) begin
            vectors++;
            if (exp_w.size() == 0) begin
                miscompares++;
                $display("FAIL word_unexpected: got data=%h keep=%0d, required no rec_en",
                         rec_data, rec_keep);
            end else begin
                w = exp_w.pop_front();
                if ({rec_data, rec_keep} !== {w.data, w.keep}) begin
                    miscompares++;
                    $display("FAIL word: got data=%h keep=%0d, required data=%h keep=%0d",
                             rec_data, rec_keep, w.data, w.keep);
                end
            end
        end
        if (rec_pkt_done) begin
            vectors++;
            if (exp_d.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got err=%0d num=%0d, required no done",
                         rec_pkt_err, rec_byte_num);
            end else begin
                d = exp_d.pop_front();
                if ({rec_pkt_err, rec_byte_num, seen_src} !== {d.err, d.num, d.src}) begin
                    miscompares++;
                    $display("FAIL done: got err=%0d num=%0d src=%b, required err=%0d num=%0d src=%b",
                             rec_pkt_err, rec_byte_num, seen_src, d.err, d.num, d.src);
                end
            end
            seen_src = 2'b00;
        end
    endtask

    task automatic cyc(input logic dv, input logic [7:0] b);
        @(negedge clk);
        sample();
        gmii_rx_dv = dv;
        gmii_rxd   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    // Build Ethernet/IPv4/UDP frame (with padding and FCS) from the payload queue
    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [31:0] dip, input logic [15:0] dport,
                         input int ihl, input int len_ovr, input bit bad_fcs);
        int          ulen;
        logic [15:0] ulen16;
        logic [15:0] tlen;
        logic [31:0] c;
        logic [31:0] fcs;
        frm.delete();
        ulen   = (len_ovr >= 0) ? len_ovr : pay.size() + 8;
        ulen16 = 16'(ulen);
        tlen   = 16'(ihl * 4 + ulen);
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back({4'h4, 4'(ihl)}); frm.push_back(8'h00);
        frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
        repeat (4) frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'd17);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'd192); frm.push_back(8'd168); frm.push_back(8'd1); frm.push_back(8'd2);
        for (int i = 0; i < 4; i++) frm.push_back(dip[31-8*i -: 8]);
        for (int i = 0; i < (ihl - 5) * 4; i++) frm.push_back(8'h00);
        frm.push_back(8'h04); frm.push_back(8'h00);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ulen16[15:8]); frm.push_back(ulen16[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pay[i]) frm.push_back(pay[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) c = crc_byte(c, frm[i]);
        fcs = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (bad_fcs) frm[frm.size()-4] = frm[frm.size()-4] ^ 8'h01;
    endtask

    // Preamble, SFD, then the first n frame bytes (all when n < 0); dv left high
    task automatic send(input int n);
        int lim;
        lim = (n < 0) ? frm.size() : n;
        repeat (7) cyc(1'b1, 8'h55);
        cyc(1'b1, 8'hd5);
        for (int i = 0; i < lim; i++) cyc(1'b1, frm[i]);
    endtask

    task automatic finish_check(input string name);
        idle(20);
        vectors++;
        if (exp_w.size() != 0 || exp_d.size() != 0) begin
            miscompares++;
            $display("FAIL pending_%s: got %0d words and %0d dones outstanding, required 0 and 0",
                     name, exp_w.size(), exp_d.size());
        end
        exp_w.delete();
        exp_d.delete();
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({rec_en, rec_data, rec_keep, rec_pkt_done, rec_pkt_err, rec_byte_num, src_id,
             drop_cnt} !== '0) begin
            miscompares++;
            $display("FAIL %s: got en=%0d data=%h keep=%0d done=%0d err=%0d num=%0d src=%b drop=%0d, required all 0",
                     name, rec_en, rec_data, rec_keep, rec_pkt_done, rec_pkt_err, rec_byte_num,
                     src_id, drop_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_values");
        rst = 1'b0;
        idle(4);
        check_zero("post_reset_idle");
    endtask

    task automatic test_good();
        pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'h01020304, 3'd4});
        exp_w.push_back('{32'h05060000, 3'd2});
        exp_d.push_back('{1'b0, 16'd6, 2'b01});
        send(-1);
        finish_check("good");
    endtask

    task automatic test_drop();
        logic [15:0] d0;
        d0 = drop_cnt;
        for (int k = 0; k < 5; k++) begin
            pay = {8'h01, 8'h02};
            case (k)
                0: build(BOARD_MAC, MAC_UNK, BOARD_IP, PORT, 5, -1, 1'b0);
                1: build(BOARD_MAC, MAC_A, {8'd192, 8'd168, 8'd1, 8'd11}, PORT, 5, -1, 1'b0);
                2: build(BOARD_MAC, MAC_A, BOARD_IP, 16'd1235, 5, -1, 1'b0);
                3: build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 4, -1, 1'b0);
                default: build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, 7, 1'b0);
            endcase
            send(-1);
            idle(5);
            vectors++;
            if (drop_cnt !== d0 + 16'(k + 1)) begin
                miscompares++;
                $display("FAIL drop_cnt_case%0d: got %0d, required %0d", k, drop_cnt, d0 + 16'(k + 1));
            end
        end
        finish_check("drop");
    endtask

    task automatic test_ihl_options();
        pay = {8'hAA};
        build(BOARD_MAC, MAC_B, BOARD_IP, PORT, 6, -1, 1'b0);
        exp_w.push_back('{32'hAA000000, 3'd1});
        exp_d.push_back('{1'b0, 16'd1, 2'b10});
        send(-1);
        finish_check("ihl6");
    endtask

    task automatic test_broadcast_full_word();
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build(BCAST, MAC_B, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'hAABBCCDD, 3'd4});
        exp_d.push_back('{1'b0, 16'd4, 2'b10});
        send(-1);
        finish_check("broadcast");
    endtask

    task automatic test_zero_len();
        pay.delete();
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_d.push_back('{1'b0, 16'd0, 2'b01});
        send(-1);
        finish_check("zero_len");
    endtask

    task automatic test_truncate();
        pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h10};
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'h11223300, 3'd3});
        exp_d.push_back('{1'b1, 16'd3, 2'b01});
        send(14 + 20 + 8 + 3);
        finish_check("truncate");
        pay = {8'hC1, 8'hC2};
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'hC1C20000, 3'd2});
        exp_d.push_back('{1'b0, 16'd2, 2'b01});
        send(-1);
        finish_check("after_truncate");
    endtask

    task automatic test_fcs();
        pay = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'h21222324, 3'd4});
        exp_w.push_back('{32'h25000000, 3'd1});
        exp_d.push_back('{1'b0, 16'd5, 2'b01});
        send(-1);
        finish_check("fcs_good");
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b1);
        exp_w.push_back('{32'h21222324, 3'd4});
        exp_w.push_back('{32'h25000000, 3'd1});
        exp_d.push_back('{BAD_FCS_ERR, 16'd5, 2'b01});
        send(-1);
        finish_check("fcs_bad");
    endtask

    task automatic test_reset_mid();
        pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        build(BOARD_MAC, MAC_B, BOARD_IP, PORT, 5, -1, 1'b0);
        send(14 + 20 + 8 + 3);
        @(negedge clk);
        rst = 1'b1;
        gmii_rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_mid_payload");
        rst = 1'b0;
        seen_src = 2'b00;
        idle(3);
        pay = {8'h41, 8'h42, 8'h43};
        build(BOARD_MAC, MAC_A, BOARD_IP, PORT, 5, -1, 1'b0);
        exp_w.push_back('{32'h41424300, 3'd3});
        exp_d.push_back('{1'b0, 16'd3, 2'b01});
        send(-1);
        finish_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_drop();
        test_ihl_options();
        test_broadcast_full_word();
        test_zero_len();
        test_truncate();
        test_fcs();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion within 2 ms, required completion");
        $fatal(1);
    end

endmodule
